// File: rtl/mem_ctrl_pipelined.sv
// Pipelined data-memory controller: registered request issue with lane steering,
// in-order tracking FIFO of in-flight accesses, and registered load/store completions.
module mem_ctrl_pipelined #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned TAG_W           = 5,
  parameter int unsigned PREG_W          = 7,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [PREG_W-1:0] req_dst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_be,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic [PREG_W-1:0] done_dst,
  output logic [31:0]       done_data,
  output logic              done_is_store,
  output logic              done_misaligned,
  output logic [CNT_W-1:0]  outstanding_cnt,
  output logic              err_unexpected_rsp
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned ENT_W = TAG_W + PREG_W + 3 + 2 + 1;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;

  logic              mreq_valid_q, mreq_valid_d;
  logic              mreq_we_q, mreq_we_d;
  logic [ADDR_W-1:0] mreq_addr_q, mreq_addr_d;
  logic [31:0]       mreq_wdata_q, mreq_wdata_d;
  logic [3:0]        mreq_be_q, mreq_be_d;

  logic [ENT_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              done_valid_q, done_valid_d;
  logic [TAG_W-1:0]  done_tag_q, done_tag_d;
  logic [PREG_W-1:0] done_dst_q, done_dst_d;
  logic [31:0]       done_data_q, done_data_d;
  logic              done_store_q, done_store_d;
  logic              done_mis_q, done_mis_d;
  logic              err_q, err_d;

  logic              accept, pop;
  logic              is_store, is_byte, is_half, mis;
  logic [1:0]        off;
  logic [ENT_W-1:0]  entry, head;
  logic [TAG_W-1:0]  h_tag;
  logic [PREG_W-1:0] h_dst;
  logic [2:0]        h_op;
  logic [1:0]        h_off;
  logic              h_mis;
  logic [31:0]       shifted, load_val;

  assign req_ready = (cnt_q < CNT_W'(MAX_OUTSTANDING)) && (!mreq_valid_q || mem_req_ready);
  assign accept    = req_valid && req_ready;
  assign pop       = mem_rsp_valid && (cnt_q != '0);

  // Request decode: access size, misalignment, FIFO entry.
  always_comb begin
    off      = req_addr[1:0];
    is_store = (req_op >= OP_SB);
    is_byte  = (req_op == OP_LB) || (req_op == OP_LBU) || (req_op == OP_SB);
    is_half  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    mis      = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
    entry    = {req_tag, req_dst, req_op, off, mis};
  end

  // Issue register: load on accept, clear after handshake, otherwise hold.
  always_comb begin
    mreq_valid_d = mreq_valid_q;
    mreq_we_d    = mreq_we_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;
    mreq_be_d    = mreq_be_q;
    if (accept) begin
      mreq_valid_d = 1'b1;
      mreq_we_d    = is_store && !mis;
      mreq_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
      if (is_byte) begin
        mreq_wdata_d = {4{req_data[7:0]}};
        mreq_be_d    = 4'b0001 << off;
      end else if (is_half) begin
        mreq_wdata_d = {2{req_data[15:0]}};
        mreq_be_d    = 4'b0011 << off;
      end else begin
        mreq_wdata_d = req_data;
        mreq_be_d    = 4'b1111;
      end
      if (mis) mreq_be_d = 4'b0000;
    end else if (mem_req_ready) begin
      mreq_valid_d = 1'b0;
    end
  end

  // Head-of-FIFO unpack and load-lane extraction.
  always_comb begin
    head    = fifo_q[rd_ptr_q];
    h_mis   = head[0];
    h_off   = head[2:1];
    h_op    = head[5:3];
    h_dst   = head[6 +: PREG_W];
    h_tag   = head[6 + PREG_W +: TAG_W];
    shifted = mem_rsp_data >> {h_off, 3'b000};
    case (h_op)
      OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      OP_LW:   load_val = mem_rsp_data;
      OP_LBU:  load_val = {24'd0, shifted[7:0]};
      OP_LHU:  load_val = {16'd0, shifted[15:0]};
      default: load_val = 32'd0;
    endcase
    if (h_mis) load_val = 32'd0;
  end

  always_comb begin
    wr_ptr_d     = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d        = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    err_d        = err_q || (mem_rsp_valid && (cnt_q == '0));
    done_valid_d = pop;
    done_tag_d   = done_tag_q;
    done_dst_d   = done_dst_q;
    done_data_d  = done_data_q;
    done_store_d = done_store_q;
    done_mis_d   = done_mis_q;
    if (pop) begin
      done_tag_d   = h_tag;
      done_dst_d   = h_dst;
      done_data_d  = load_val;
      done_store_d = (h_op >= OP_SB);
      done_mis_d   = h_mis;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mreq_valid_q <= 1'b0;
      mreq_we_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
      mreq_be_q    <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      done_dst_q   <= '0;
      done_data_q  <= '0;
      done_store_q <= 1'b0;
      done_mis_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mreq_valid_q <= mreq_valid_d;
      mreq_we_q    <= mreq_we_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
      mreq_be_q    <= mreq_be_d;
      if (accept) fifo_q[wr_ptr_q] <= entry;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      done_dst_q   <= done_dst_d;
      done_data_q  <= done_data_d;
      done_store_q <= done_store_d;
      done_mis_q   <= done_mis_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_valid      = mreq_valid_q;
  assign mem_req_we         = mreq_we_q;
  assign mem_req_addr       = mreq_addr_q;
  assign mem_req_wdata      = mreq_wdata_q;
  assign mem_req_be         = mreq_be_q;
  assign done_valid         = done_valid_q;
  assign done_tag           = done_tag_q;
  assign done_dst           = done_dst_q;
  assign done_data          = done_data_q;
  assign done_is_store      = done_store_q;
  assign done_misaligned    = done_mis_q;
  assign outstanding_cnt    = cnt_q;
  assign err_unexpected_rsp = err_q;

endmodule
